// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the register-sharing arbiter.
package reg_share_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // First set bit of req scanning ptr, ptr+1, ... mod n; returns 0 when none is set (n <= 32).
  function automatic int unsigned rr_index(input logic [31:0] req, input int unsigned ptr,
                                           input int unsigned n);
    int unsigned k;
    int unsigned pick;
    logic found;
    pick = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      k = (ptr + i) % n;
      if (i < n && !found && req[k[4:0]]) begin
        pick = k;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: oldest-after-pointer request wins.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int unsigned R  = 4,
  parameter int unsigned PW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx    = PW'(rr_index(32'(req), 32'(ptr), R));
    any    = |req;
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter with optional bounded burst lock, driving one shared W-bit
// enabled register.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned R         = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic [R-1:0]         req,
  input  logic [R-1:0]         lock,
  input  logic [R*W-1:0]       wdata,
  output logic [R-1:0]         gnt,
  output logic [$clog2(R)-1:0] owner,
  output logic                 busy,
  output logic [W-1:0]         q
);

  localparam int unsigned PW = $clog2(R);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] LAST = PW'(R - 1);
  localparam logic [CW:0] MAXB = (CW + 1)'(MAX_BURST);

  arb_state_t    state, state_next;
  logic [PW-1:0] ptr, ptr_next, owner_next, gidx;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW:0]   cnt_inc;
  logic [R-1:0]  pick_onehot;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic          en;
  logic [W-1:0]  d;

  rr_pick #(.R(R), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign busy    = (state == BURST);
  assign cnt_inc = {1'b0, cnt} + 1'b1;

  // While locked only the owner is looked at; the burst ends on unlock, on the
  // length cap, or on the owner withdrawing its request (no write that cycle).
  always_comb begin
    gnt        = '0;
    en         = 1'b0;
    gidx       = pick_idx;
    state_next = state;
    cnt_next   = cnt;
    owner_next = owner;
    ptr_next   = ptr;
    if (rest) begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt        = pick_onehot;
            en         = 1'b1;
            owner_next = pick_idx;
            ptr_next   = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
            if (lock[pick_idx] && MAX_BURST > 1) begin
              state_next = BURST;
              cnt_next   = CW'(1);
            end
          end
        end
        BURST: begin
          gidx = owner;
          if (req[owner]) begin
            gnt[owner] = 1'b1;
            en         = 1'b1;
            if (lock[owner] && cnt_inc < MAXB) begin
              cnt_next = cnt_inc[CW-1:0];
            end else begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign d = wdata[gidx*W +: W];

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      owner <= owner_next;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed table, hand sequences and
// randomized traffic against a behavioural model.
module tb_reg_share_arbiter;

  localparam int W  = 4;
  localparam int R  = 4;
  localparam int MB = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rest;
  logic [R-1:0]  req;
  logic [R-1:0]  lock;
  logic [R*W-1:0] wdata;
  logic [R-1:0]  gnt;
  logic [PW-1:0] owner;
  logic          busy;
  logic [W-1:0]  q;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(.W(W), .R(R), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rest  (rest),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q)
  );

  typedef struct {
    logic [R-1:0]   req;
    logic [R-1:0]   lock;
    logic [R*W-1:0] wdata;
    logic [R-1:0]   gnt;
    logic [W-1:0]   q;
    logic           busy;
  } row_t;

  row_t tab[10];

  // Behavioural model: grants remaining in the current locked burst.
  int m_q, m_ptr, m_owner, m_left;
  bit m_locked;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_ptr = 0; m_owner = 0; m_left = 0; m_locked = 0;
  endtask

  function automatic int model_gnt_idx();
    if (!rest) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int i = 0; i < R; i++)
      if (req[(m_ptr + i) % R]) return (m_ptr + i) % R;
    return -1;
  endfunction

  function automatic int idx_to_onehot(input int k);
    return (k < 0) ? 0 : (1 << k);
  endfunction

  task automatic model_clock();
    int k;
    k = model_gnt_idx();
    if (m_locked) begin
      if (k >= 0) begin
        m_q = int'(wdata[k*W +: W]);
        m_left--;
        if (!lock[k] || m_left == 0) m_locked = 0;
      end else begin
        m_locked = 0;
      end
    end else if (k >= 0) begin
      m_q = int'(wdata[k*W +: W]);
      m_owner = k;
      m_ptr = (k + 1) % R;
      if (lock[k] && MB > 1) begin
        m_locked = 1;
        m_left = MB - 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rest = 1'b0; req = '0; lock = '0;
    #1;
    @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [R-1:0] r, input logic [R-1:0] l,
                                input logic [R*W-1:0] wd);
    @(negedge clk);
    req = r; lock = l; wdata = wd;
    #1;
  endtask

  task automatic check_output(input string name, input logic [R-1:0] eg,
                              input logic [W-1:0] eq, input logic eb);
    check({name, ".gnt"}, int'(gnt), int'(eg));
    check({name, ".q"}, int'(q), int'(eq));
    check({name, ".busy"}, int'(busy), int'(eb));
  endtask

  initial begin
    rest = 1'b1; req = '0; lock = '0; wdata = '0;

    // Round robin, then burst cap with a competing requester.
    tab[0] = '{4'b1111, 4'b0000, 16'h4321, 4'b0001, 4'h0, 1'b0};
    tab[1] = '{4'b1111, 4'b0000, 16'h4321, 4'b0010, 4'h1, 1'b0};
    tab[2] = '{4'b1111, 4'b0000, 16'h4321, 4'b0100, 4'h2, 1'b0};
    tab[3] = '{4'b1111, 4'b0000, 16'h4321, 4'b1000, 4'h3, 1'b0};
    tab[4] = '{4'b1111, 4'b0000, 16'h4321, 4'b0001, 4'h4, 1'b0};
    tab[5] = '{4'b0011, 4'b0001, 16'h4321, 4'b0001, 4'h0, 1'b0};
    tab[6] = '{4'b0011, 4'b0001, 16'h4321, 4'b0001, 4'h1, 1'b1};
    tab[7] = '{4'b0011, 4'b0001, 16'h4321, 4'b0001, 4'h1, 1'b1};
    tab[8] = '{4'b0011, 4'b0001, 16'h4321, 4'b0001, 4'h1, 1'b1};
    tab[9] = '{4'b0011, 4'b0001, 16'h4321, 4'b0010, 4'h1, 1'b0};

    // Reset holds grant off even with requests pending.
    @(negedge clk);
    rest = 1'b0; req = 4'b1111; wdata = 16'h4321;
    #1;
    check_output("reset", 4'b0000, 4'h0, 1'b0);
    check("reset.owner", int'(owner), 0);
    rest = 1'b1;
    #1;
    check("release.gnt", int'(gnt), 4'b0001);

    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 5) do_reset();
      apply_stimulus(tab[i].req, tab[i].lock, tab[i].wdata);
      check_output($sformatf("row%0d", i), tab[i].gnt, tab[i].q, tab[i].busy);
    end

    // Early unlock: owner 2 drops lock in its first burst cycle, 3 wins next.
    do_reset();
    apply_stimulus(4'b0100, 4'b0100, 16'h4321);
    check_output("unlock.c1", 4'b0100, 4'h0, 1'b0);
    apply_stimulus(4'b1100, 4'b0000, 16'h4321);
    check_output("unlock.c2", 4'b0100, 4'h3, 1'b1);
    apply_stimulus(4'b1100, 4'b0000, 16'h4321);
    check_output("unlock.c3", 4'b1000, 4'h3, 1'b0);

    // Owner withdraws mid-burst: no write, back to IDLE with ptr past owner.
    do_reset();
    apply_stimulus(4'b0010, 4'b0010, 16'h4321);
    check_output("drop.c1", 4'b0010, 4'h0, 1'b0);
    apply_stimulus(4'b0001, 4'b0000, 16'h4321);
    check_output("drop.c2", 4'b0000, 4'h2, 1'b1);
    apply_stimulus(4'b0001, 4'b0000, 16'h4321);
    check_output("drop.c3", 4'b0001, 4'h2, 1'b0);

    // Async reset mid-burst clears immediately and rewinds the pointer.
    do_reset();
    apply_stimulus(4'b0100, 4'b0100, 16'h4321);
    @(posedge clk);
    #2;
    check("areset.pre_busy", int'(busy), 1);
    check("areset.pre_q", int'(q), 3);
    rest = 1'b0;
    #1;
    check_output("areset.low", 4'b0000, 4'h0, 1'b0);
    @(negedge clk);
    rest = 1'b1; req = 4'b1111; lock = '0;
    #1;
    check("areset.after_gnt", int'(gnt), 4'b0001);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req   = R'($urandom_range(0, 15));
      lock  = R'($urandom_range(0, 15));
      wdata = (R*W)'($urandom);
      if (c % 50 == 49) begin
        rest = 1'b0;
        #1;
        model_reset();
        check("rand.rst_q", int'(q), 0);
        rest = 1'b1;
      end
      #1;
      check("rand.gnt", int'(gnt), idx_to_onehot(model_gnt_idx()));
      check("rand.q", int'(q), m_q);
      check("rand.busy", int'(busy), int'(m_locked));
      check("rand.owner", int'(owner), m_owner);
      model_clock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
